// File: rtl/palette_entry_sequencer_if.sv
// rtl/palette_entry_sequencer_if.sv - key stream, palette read port and status bundle
interface palette_entry_sequencer_if #(
    parameter int SLOT_W = 3
);
    logic              keypressed;
    logic [7:0]        scancode;
    logic [SLOT_W-1:0] rd_slot;
    logic [11:0]       rd_color;
    logic [11:0]       active_color;
    logic [SLOT_W-1:0] active_slot;
    logic [3:0]        state;
    logic              commit_pulse;

    modport master (
        output keypressed, scancode, rd_slot,
        input  rd_color, active_color, active_slot, state, commit_pulse
    );

    modport slave (
        input  keypressed, scancode, rd_slot,
        output rd_color, active_color, active_slot, state, commit_pulse
    );
endinterface

// File: rtl/palette_entry_sequencer.sv
// rtl/palette_entry_sequencer.sv - keyboard-driven slot/R/G/B/confirm palette entry; SLOT0_LOCK_EN makes slot 0 read-only
module palette_entry_sequencer #(
    parameter int SLOT_W      = 3,
    parameter int TIMEOUT_CYC = 100000000
) (
    input logic                       clk,
    input logic                       rstn,
    palette_entry_sequencer_if.slave  bus
);
    localparam int NUM_SLOTS = 1 << SLOT_W;

    typedef enum logic [3:0] {
        S_SLOT      = 4'd0,
        S_SLOT_REL  = 4'd1,
        S_RED       = 4'd2,
        S_RED_REL   = 4'd3,
        S_GREEN     = 4'd4,
        S_GREEN_REL = 4'd5,
        S_BLUE      = 4'd6,
        S_BLUE_REL  = 4'd7,
        S_CONFIRM   = 4'd8,
        S_DRAIN     = 4'd9
    } state_t;

    state_t            st;
    logic [11:0]       pal [NUM_SLOTS];
    logic [SLOT_W-1:0] cap_slot;
    logic [SLOT_W-1:0] act_slot;
    logic [3:0]        cap_r, cap_g, cap_b;
    logic [31:0]       cnt;
    logic [11:0]       rd;
    logic              commit;

    // {mapped, level}; escape and every other unlisted code read as unmapped
    function automatic logic [4:0] key_level(input logic [7:0] sc);
        case (sc)
            8'h70:   key_level = 5'h10;
            8'h69:   key_level = 5'h12;
            8'h72:   key_level = 5'h14;
            8'h7A:   key_level = 5'h16;
            8'h6B:   key_level = 5'h18;
            8'h73:   key_level = 5'h1A;
            8'h74:   key_level = 5'h1C;
            8'h6C:   key_level = 5'h1E;
            8'h75:   key_level = 5'h1F;
            default: key_level = 5'h00;
        endcase
    endfunction

    logic [4:0]        kmap;
    logic              mapped;
    logic [3:0]        lvl;
    logic [2:0]        lvl_hi;
    logic [SLOT_W-1:0] key_slot;
    logic              tmo_hit;
    logic              wr_ok;

    always_comb begin
        kmap     = key_level(bus.scancode);
        mapped   = kmap[4];
        lvl      = kmap[3:0];
        lvl_hi   = lvl[3:1];
        key_slot = lvl_hi[SLOT_W-1:0];
        tmo_hit  = (TIMEOUT_CYC != 0) && (cnt == 32'(TIMEOUT_CYC - 1))
                   && (st != S_SLOT) && (st != S_DRAIN);
`ifdef SLOT0_LOCK_EN
        wr_ok    = (cap_slot != '0);
`else
        wr_ok    = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= S_SLOT;
            cap_slot <= '0;
            act_slot <= '0;
            cap_r    <= '0;
            cap_g    <= '0;
            cap_b    <= '0;
            cnt      <= '0;
            rd       <= 12'hFFF;
            commit   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) pal[i] <= 12'hFFF;
        end else begin
            rd     <= pal[bus.rd_slot];
            commit <= 1'b0;
            cnt    <= (bus.keypressed || st == S_SLOT) ? 32'd0 : cnt + 32'd1;
            if (tmo_hit) begin
                st  <= S_DRAIN;
                cnt <= '0;
            end else begin
                case (st)
                    S_SLOT: if (bus.keypressed && mapped) begin
                        cap_slot <= key_slot;
                        st       <= S_SLOT_REL;
                    end
                    S_RED: if (bus.keypressed) begin
                        cap_r <= lvl;
                        st    <= mapped ? S_RED_REL : S_DRAIN;
                    end
                    S_GREEN: if (bus.keypressed) begin
                        cap_g <= lvl;
                        st    <= mapped ? S_GREEN_REL : S_DRAIN;
                    end
                    S_BLUE: if (bus.keypressed) begin
                        cap_b <= lvl;
                        st    <= mapped ? S_BLUE_REL : S_DRAIN;
                    end
                    S_SLOT_REL:  if (!bus.keypressed) st <= S_RED;
                    S_RED_REL:   if (!bus.keypressed) st <= S_GREEN;
                    S_GREEN_REL: if (!bus.keypressed) st <= S_BLUE;
                    S_BLUE_REL:  if (!bus.keypressed) st <= S_CONFIRM;
                    S_CONFIRM: if (bus.keypressed) begin
                        if (bus.scancode == 8'h5A && wr_ok) begin
                            pal[cap_slot] <= {cap_b, cap_g, cap_r};
                            commit        <= 1'b1;
                            act_slot      <= cap_slot;
                        end
                        st <= S_DRAIN;
                    end
                    S_DRAIN: if (!bus.keypressed) st <= S_SLOT;
                    default: st <= S_DRAIN;
                endcase
            end
        end
    end

    assign bus.rd_color     = rd;
    assign bus.active_color = pal[act_slot];
    assign bus.active_slot  = act_slot;
    assign bus.state        = st;
    assign bus.commit_pulse = commit;
endmodule

// File: tb/tb_palette_entry_sequencer.sv
// tb/tb_palette_entry_sequencer.sv - model-checked bench for palette_entry_sequencer
module tb_palette_entry_sequencer;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          kp = 1'b0;
    logic [7:0]    sc = 8'h00;
    logic [SW-1:0] rs = '0;

    always #5 clk = ~clk;

    palette_entry_sequencer_if #(.SLOT_W(SW)) bus_a ();
    palette_entry_sequencer_if #(.SLOT_W(SW)) bus_b ();

    assign bus_a.keypressed = kp;
    assign bus_a.scancode   = sc;
    assign bus_a.rd_slot    = rs;
    assign bus_b.keypressed = kp;
    assign bus_b.scancode   = sc;
    assign bus_b.rd_slot    = rs;

    palette_entry_sequencer #(.SLOT_W(SW), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a));
    palette_entry_sequencer #(.SLOT_W(SW), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;
    int pulses_a = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: entry is a phase 0..4 (slot,R,G,B,confirm), either awaiting a press or a release
    int          tmo_cfg [2] = '{16, 0};
    int          m_phase [2];
    bit          m_wait  [2];
    bit          m_drain [2];
    int          m_cnt   [2];
    int          m_vals  [2][4];
    logic [11:0] m_pal   [2][8];
    int          m_act   [2];
    bit          m_commit[2];
    logic [11:0] m_rd    [2];
    bit          m_lock;

    function automatic int level_of(input logic [7:0] code);
        case (code)
            8'h70: return 0;   8'h69: return 2;   8'h72: return 4;
            8'h7A: return 6;   8'h6B: return 8;   8'h73: return 10;
            8'h74: return 12;  8'h6C: return 14;  8'h75: return 15;
            default: return -1;
        endcase
    endfunction

    initial begin
`ifdef SLOT0_LOCK_EN
        m_lock = 1'b1;
`else
        m_lock = 1'b0;
`endif
    end

    always @(posedge clk or negedge rstn) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                m_phase[d] = 0; m_wait[d] = 0; m_drain[d] = 0; m_cnt[d] = 0;
                m_act[d] = 0; m_commit[d] = 0; m_rd[d] = 12'hFFF;
                for (int k = 0; k < 4; k++) m_vals[d][k] = 0;
                for (int k = 0; k < 8; k++) m_pal[d][k] = 12'hFFF;
            end else begin
                bit idle_slot, busy, tmo;
                int lv;
                idle_slot = !m_drain[d] && m_phase[d] == 0 && !m_wait[d];
                busy = !m_drain[d] && !idle_slot;
                tmo = tmo_cfg[d] > 0 && m_cnt[d] == tmo_cfg[d] - 1 && busy;
                m_rd[d] = m_pal[d][rs];
                m_commit[d] = 0;
                m_cnt[d] = (kp || idle_slot) ? 0 : m_cnt[d] + 1;
                lv = level_of(sc);
                if (tmo) begin
                    m_drain[d] = 1; m_cnt[d] = 0;
                end else if (m_drain[d]) begin
                    if (!kp) begin m_drain[d] = 0; m_phase[d] = 0; m_wait[d] = 0; end
                end else if (m_wait[d]) begin
                    if (!kp) begin m_wait[d] = 0; m_phase[d]++; end
                end else if (kp) begin
                    if (m_phase[d] == 4) begin
                        int slot;
                        slot = m_vals[d][0] / 2;
                        if (sc == 8'h5A && !(m_lock && slot == 0)) begin
                            m_pal[d][slot] = 12'((m_vals[d][3] << 8) | (m_vals[d][2] << 4) | m_vals[d][1]);
                            m_commit[d] = 1;
                            m_act[d] = slot;
                        end
                        m_drain[d] = 1;
                    end else if (lv >= 0) begin
                        m_vals[d][m_phase[d]] = lv;
                        m_wait[d] = 1;
                    end else if (m_phase[d] != 0) begin
                        m_drain[d] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [11:0] o_rd, o_ac;
            logic [3:0]  o_st;
            logic [2:0]  o_as;
            logic        o_cp;
            int          exp_st;
            if (d == 0) begin
                o_rd = bus_a.rd_color; o_ac = bus_a.active_color; o_st = bus_a.state;
                o_as = bus_a.active_slot; o_cp = bus_a.commit_pulse;
            end else begin
                o_rd = bus_b.rd_color; o_ac = bus_b.active_color; o_st = bus_b.state;
                o_as = bus_b.active_slot; o_cp = bus_b.commit_pulse;
            end
            exp_st = m_drain[d] ? 9 : m_phase[d] * 2 + int'(m_wait[d]);
            chk(d == 0 ? "state_a" : "state_b", 32'(o_st), 32'(exp_st));
            chk(d == 0 ? "commit_a" : "commit_b", 32'(o_cp), 32'(m_commit[d]));
            chk(d == 0 ? "act_slot_a" : "act_slot_b", 32'(o_as), 32'(m_act[d]));
            chk(d == 0 ? "act_color_a" : "act_color_b", 32'(o_ac), 32'(m_pal[d][m_act[d]]));
            chk(d == 0 ? "rd_color_a" : "rd_color_b", 32'(o_rd), 32'(m_rd[d]));
        end
        if (rstn && bus_a.commit_pulse === 1'b1) pulses_a++;
    end

    task automatic key(input logic [7:0] code, input int hold, input int gap);
        kp = 1'b1; sc = code;
        repeat (hold) @(negedge clk);
        kp = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int p0;
        bit seen;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("lit_reset_state", 32'(bus_a.state), 32'd0);
        for (int s = 0; s < 8; s++) begin
            rs = 3'(s);
            @(negedge clk);
        end
        @(negedge clk);

        // full commit of 08F into slot 2
        key(8'h72, 2, 2); key(8'h75, 2, 2); key(8'h6B, 2, 2); key(8'h70, 2, 2);
        p0 = pulses_a;
        kp = 1'b1; sc = 8'h5A;
        repeat (2) @(negedge clk);
        chk("lit_drain_held", 32'(bus_a.state), 32'd9);
        kp = 1'b0;
        repeat (2) @(negedge clk);
        chk("lit_back_to_slot", 32'(bus_a.state), 32'd0);
        rs = 3'd2;
        repeat (2) @(negedge clk);
        chk("lit_pal2", 32'(bus_a.rd_color), 32'h08F);
        chk("lit_active_slot", 32'(bus_a.active_slot), 32'd2);
        chk("lit_active_color", 32'(bus_a.active_color), 32'h08F);
        chk("lit_one_pulse", 32'(pulses_a - p0), 32'd1);

        // escape abort
        p0 = pulses_a;
        key(8'h69, 2, 2); key(8'h75, 2, 2);
        kp = 1'b1; sc = 8'h76;
        repeat (3) @(negedge clk);
        chk("lit_esc_drain", 32'(bus_a.state), 32'd9);
        kp = 1'b0;
        rs = 3'd1;
        repeat (2) @(negedge clk);
        chk("lit_esc_pal1", 32'(bus_a.rd_color), 32'hFFF);
        chk("lit_esc_no_pulse", 32'(pulses_a - p0), 32'd0);

        // unmapped key in SLOT, then held key
        key(8'h1C, 5, 1);
        chk("lit_unmapped_slot", 32'(bus_a.state), 32'd0);
        kp = 1'b1; sc = 8'h70;
        repeat (50) @(negedge clk);
        chk("lit_held_rel", 32'(bus_a.state), 32'd1);
        kp = 1'b0;
        @(negedge clk);
        chk("lit_held_red", 32'(bus_a.state), 32'd2);
        key(8'h76, 2, 2);

        // timeout: dut_a abandons after idle, dut_b has no timeout
        key(8'h69, 2, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.state == 4'd9) seen = 1;
        end
        chk("lit_timeout_seen", 32'(seen), 32'd1);
        chk("lit_no_timeout_b", 32'(bus_b.state), 32'd2);
        @(negedge clk);
        chk("lit_timeout_slot", 32'(bus_a.state), 32'd0);
        key(8'h76, 2, 2);

        // read/write collision on slot 3 with ACE
        rs = 3'd3;
        key(8'h7A, 2, 2); key(8'h6C, 2, 2); key(8'h74, 2, 2); key(8'h73, 2, 2);
        kp = 1'b1; sc = 8'h5A;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.commit_pulse === 1'b1) seen = 1;
        end
        chk("lit_collide_pulse", 32'(seen), 32'd1);
        chk("lit_collide_old", 32'(bus_a.rd_color), 32'hFFF);
        @(negedge clk);
        chk("lit_collide_new", 32'(bus_a.rd_color), 32'hACE);
        kp = 1'b0;
        repeat (2) @(negedge clk);

        // commit attempt to slot 0
        p0 = pulses_a;
        rs = 3'd0;
        key(8'h70, 2, 2); key(8'h6C, 2, 2); key(8'h6C, 2, 2); key(8'h6C, 2, 2);
        key(8'h5A, 2, 3);
`ifdef SLOT0_LOCK_EN
        chk("lit_lock_pulses", 32'(pulses_a - p0), 32'd0);
        chk("lit_lock_pal0", 32'(bus_a.rd_color), 32'hFFF);
        chk("lit_lock_active", 32'(bus_a.active_slot), 32'd3);
`else
        chk("lit_slot0_pulses", 32'(pulses_a - p0), 32'd1);
        chk("lit_slot0_pal0", 32'(bus_a.rd_color), 32'hEEE);
        chk("lit_slot0_active", 32'(bus_a.active_slot), 32'd0);
`endif

        // reset mid-sequence
        key(8'h72, 2, 2); key(8'h75, 2, 2);
        kp = 1'b1; sc = 8'h6B;
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("lit_midreset_state", 32'(bus_a.state), 32'd0);
        chk("lit_midreset_active", 32'(bus_a.active_color), 32'hFFF);
        kp = 1'b0;
        #2 rstn = 1'b1;
        rs = 3'd3;
        repeat (3) @(negedge clk);
        chk("lit_midreset_pal3", 32'(bus_a.rd_color), 32'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
